// File: rtl/access_arbiter_pkg.sv
// access_arbiter_pkg: shared user-code constants, rank width and FSM state encodings for the access arbiter
package access_arbiter_pkg;
    localparam logic [2:0] CODE_IDLE = 3'b000;
    localparam logic [2:0] CODE_R1   = 3'b110;
    localparam logic [2:0] CODE_R2   = 3'b001;
    localparam logic [2:0] CODE_R3   = 3'b011;
    localparam logic [2:0] CODE_R4   = 3'b101;
    localparam int RANK_W = 3;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;
endpackage

// File: rtl/access_arbiter_code_rank.sv
// code_rank: maps a 3-bit user code to its priority rank (0 = no request)
//   code    in  3       user code
//   rank    out RANK_W  1..4 for valid codes, 0 otherwise
//   valid   out 1       code is one of the four ranked codes
//   invalid out 1       code is non-idle but not rankable
module code_rank
    import access_arbiter_pkg::*;
(
    input  logic [2:0]        code,
    output logic [RANK_W-1:0] rank,
    output logic              valid,
    output logic              invalid
);
    assign rank = code == CODE_R4 ? RANK_W'(4) :
                  code == CODE_R3 ? RANK_W'(3) :
                  code == CODE_R2 ? RANK_W'(2) :
                  code == CODE_R1 ? RANK_W'(1) : '0;
    assign valid   = rank != '0;
    assign invalid = code != CODE_IDLE && !valid;
endmodule

// File: rtl/access_arbiter.sv
// access_arbiter: two-interface priority arbiter with pending-requester memory and optional hold timeout (ARB_TIMEOUT_EN)
//   clk, rst (async, active-high)
//   req0_code / req1_code in  3  interface user codes, 000 = no request
//   done                  in  1  owner release pulse
//   grant                 out 2  one-hot owner, [0] = IF0, [1] = IF1
//   grant_code            out 3  owner's code, 000 when idle
//   pending_valid/_code   out    deferred requester
//   busy                  out 1  FSM not idle
//   err_invalid           out 1  invalid code seen on previous cycle
module access_arbiter
    import access_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req0_code,
    input  logic [2:0] req1_code,
    input  logic       done,
    output logic [1:0] grant,
    output logic [2:0] grant_code,
    output logic       pending_valid,
    output logic [2:0] pending_code,
    output logic       busy,
    output logic       err_invalid
);
    logic [RANK_W-1:0] r0, r1;
    logic v0, v1, i0, i1;
    logic [1:0] state, state_n;
    logic pend_if, pi_n, pv_n;
    logic [2:0] pc_n;
    logic timeout;

    code_rank u_rank0 (.code(req0_code), .rank(r0), .valid(v0), .invalid(i0));
    code_rank u_rank1 (.code(req1_code), .rank(r1), .valid(v1), .invalid(i1));

    wire in_gnt = state == ST_GNT0 || state == ST_GNT1;
    wire owner = state == ST_GNT1;
    wire own_v = owner ? v1 : v0;
    wire oth_v = owner ? v0 : v1;
    wire [2:0] own_code = owner ? req1_code : req0_code;
    wire [2:0] oth_code = owner ? req0_code : req1_code;
    wire p_v = pend_if ? v1 : v0;
    wire [2:0] p_code = pend_if ? req1_code : req0_code;
    // ties go to IF0
    wire win0 = v0 && (!v1 || r0 >= r1);
    wire win1 = v1 && !win0;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    assign timeout = in_gnt && hold_cnt == CNT_W'(HOLD_MAX - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) hold_cnt <= '0;
        else hold_cnt <= (in_gnt && state_n == state) ? hold_cnt + 1'b1 : '0;
`else
    wire cfg_unused = HOLD_MAX > CNT_W;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        pv_n = pending_valid;
        pc_n = pending_code;
        pi_n = pend_if;
        // a waiting requester tracks its interface's code and drops out when it withdraws
        if (pending_valid) begin
            pv_n = p_v;
            pc_n = p_v ? p_code : CODE_IDLE;
        end
        if (in_gnt) begin
            if (!pending_valid && oth_v) begin
                pv_n = 1'b1;
                pi_n = ~owner;
                pc_n = oth_code;
            end else if (timeout && own_v && !pending_valid) begin
                pv_n = 1'b1;
                pi_n = owner;
                pc_n = own_code;
            end
            if (done || !own_v || timeout) state_n = ST_REL;
        end else if (state == ST_REL && pending_valid && p_v && p_code == pending_code) begin
            state_n = pend_if ? ST_GNT1 : ST_GNT0;
            pv_n = 1'b0;
            pc_n = CODE_IDLE;
        end else begin
            state_n = win0 ? ST_GNT0 : win1 ? ST_GNT1 : ST_IDLE;
            pv_n = v0 && v1;
            pi_n = win0;
            pc_n = (v0 && v1) ? (win0 ? req1_code : req0_code) : CODE_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            grant_code <= CODE_IDLE;
            pending_valid <= 1'b0;
            pending_code <= CODE_IDLE;
            pend_if <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            state <= state_n;
            grant <= {state_n == ST_GNT1, state_n == ST_GNT0};
            grant_code <= state_n == ST_GNT0 ? req0_code : state_n == ST_GNT1 ? req1_code : CODE_IDLE;
            pending_valid <= pv_n;
            pending_code <= pc_n;
            pend_if <= pi_n;
            err_invalid <= i0 | i1;
        end
    end

    assign busy = state != ST_IDLE;
endmodule

// File: tb/tb_access_arbiter.sv
// tb_access_arbiter: directed self-checking bench for access_arbiter
module tb_access_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 16;
`endif
    logic clk = 1'b0, rst = 1'b1, done = 1'b0;
    logic [2:0] req0_code = 3'b000, req1_code = 3'b000;
    logic [1:0] grant;
    logic [2:0] grant_code, pending_code;
    logic pending_valid, busy, err_invalid;
    int errors = 0, checks = 0;

    access_arbiter #(.HOLD_MAX(HM), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .req0_code(req0_code), .req1_code(req1_code), .done(done),
        .grant(grant), .grant_code(grant_code), .pending_valid(pending_valid),
        .pending_code(pending_code), .busy(busy), .err_invalid(err_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        req0_code = 3'b101;
        step(3);
        chk("rst_grant", 4'(grant), 4'b00);
        chk("rst_err", 4'(err_invalid), 4'b0);
        chk("rst_busy", 4'(busy), 4'b0);
        rst = 1'b0;
        step();
        chk("t1_grant", 4'(grant), 4'b01);
        chk("t1_gcode", 4'(grant_code), 4'b101);
        chk("t1_busy", 4'(busy), 4'b1);
        req0_code = 3'b000;
        step();
        chk("t1_rel_grant", 4'(grant), 4'b00);
        chk("t1_rel_busy", 4'(busy), 4'b1);
        step();
        chk("t1_idle_busy", 4'(busy), 4'b0);

        req0_code = 3'b110;
        req1_code = 3'b001;
        step();
        chk("t2_grant", 4'(grant), 4'b10);
        chk("t2_gcode", 4'(grant_code), 4'b001);
        chk("t2_pv", 4'(pending_valid), 4'b1);
        chk("t2_pcode", 4'(pending_code), 4'b110);
        done = 1'b1;
        step();
        done = 1'b0;
        req1_code = 3'b000;
        chk("t2_rel_grant", 4'(grant), 4'b00);
        chk("t2_rel_pv", 4'(pending_valid), 4'b1);
        step();
        chk("t2_g0_grant", 4'(grant), 4'b01);
        chk("t2_g0_gcode", 4'(grant_code), 4'b110);
        chk("t2_g0_pv", 4'(pending_valid), 4'b0);
        req0_code = 3'b000;
        step(2);
        chk("t2_idle", 4'(busy), 4'b0);

        req0_code = 3'b011;
        req1_code = 3'b011;
        step();
        chk("t3_grant", 4'(grant), 4'b01);
        chk("t3_pcode", 4'(pending_code), 4'b011);
        chk("t3_pv", 4'(pending_valid), 4'b1);
        req1_code = 3'b000;
        step();
        chk("t3_pv_drop", 4'(pending_valid), 4'b0);
        chk("t3_hold", 4'(grant), 4'b01);
        req0_code = 3'b000;
        step();
        chk("t3_fall", 4'(grant), 4'b00);
        step();

        req0_code = 3'b101;
        req1_code = 3'b110;
        step();
        chk("pf_grant", 4'(grant), 4'b01);
        chk("pf_pcode0", 4'(pending_code), 4'b110);
        req1_code = 3'b011;
        step();
        chk("pf_pcode1", 4'(pending_code), 4'b011);
        chk("pf_pv", 4'(pending_valid), 4'b1);
        req0_code = 3'b000;
        req1_code = 3'b000;
        step(2);

        req0_code = 3'b111;
        step();
        chk("t4_err", 4'(err_invalid), 4'b1);
        chk("t4_grant", 4'(grant), 4'b00);
        chk("t4_busy", 4'(busy), 4'b0);
        req0_code = 3'b000;
        step();
        chk("t4_err_clr", 4'(err_invalid), 4'b0);

        req0_code = 3'b110;
        req1_code = 3'b101;
        step();
        chk("t6_grant", 4'(grant), 4'b10);
        chk("t6_pv", 4'(pending_valid), 4'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_grant", 4'(grant), 4'b00);
        chk("t6_rst_pv", 4'(pending_valid), 4'b0);
        chk("t6_rst_busy", 4'(busy), 4'b0);
        step();
        rst = 1'b0;
        step();
        chk("t6_re_grant", 4'(grant), 4'b10);
        chk("t6_re_pcode", 4'(pending_code), 4'b110);

`ifdef ARB_TIMEOUT_EN
        rst = 1'b1;
        req0_code = 3'b001;
        req1_code = 3'b101;
        step();
        rst = 1'b0;
        step();
        chk("t5_g1_first", 4'(grant), 4'b10);
        chk("t5_pcode", 4'(pending_code), 4'b001);
        step(3);
        chk("t5_g1_last", 4'(grant), 4'b10);
        step();
        chk("t5_rel", 4'(grant), 4'b00);
        step();
        chk("t5_g0", 4'(grant), 4'b01);
        step();
        chk("t5_pv1", 4'(pending_valid), 4'b1);
        chk("t5_pcode1", 4'(pending_code), 4'b101);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
